prbs_err_monitor: RTL and testbench



---
 rtl/prbs_mon_pkg.sv | 19 +
 rtl/lib_popcount.sv | 20 ++
 rtl/prbs_err_monitor.sv | 136 +++++++++++++
 tb/tb_prbs_err_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_mon_pkg.sv
// Shared types and helpers for the PRBS error monitor and other checker consumers.
package prbs_mon_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } mon_state_e;

    // Bits needed to hold values 0..n-1; never less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/lib_popcount.sv
// Combinational population count of an NBITS-wide vector.
module lib_popcount
    import prbs_mon_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0]             BITS,
    output logic [clog2(NBITS+1)-1:0]    COUNT
);

    localparam int PCW = clog2(NBITS + 1);

    always_comb begin
        COUNT = '0;
        for (int i = 0; i < NBITS; i++) begin
            COUNT = COUNT + PCW'(BITS[i]);
        end
    end

endmodule

// File: rtl/prbs_err_monitor.sv
// Lock qualification, windowed loss-of-sync detection and saturating error/word
// counters behind the parallel PRBS checker. Two-stage pipeline: popcount, then update.
module prbs_err_monitor
    import prbs_mon_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int CNT_W      = 32,
    parameter int LOCK_WORDS = 64,
    parameter int WIN_WORDS  = 1024,
    parameter int LOSS_ERRS  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NBITS-1:0] ERR_IN,
    input  logic             ERR_VALID,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR_PULSE,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [CNT_W-1:0] SYNC_LOSS_CNT
);

    localparam int PCW    = clog2(NBITS + 1);
    localparam int RUN_W  = clog2(LOCK_WORDS + 1);
    localparam int WCNT_W = clog2(WIN_WORDS + 1);
    // Window sum stays below LOSS_ERRS between words, so one word can overshoot by NBITS.
    localparam int WSUM_W = clog2(LOSS_ERRS + NBITS + 1);
    localparam int SUM_W  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PCW-1:0]    pc_comb, pc_q;
    logic              v1_q;
    mon_state_e        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [WSUM_W-1:0] wsum_q, wsum_d, wsum_nx;
    logic              cnt_en, loss;
    logic [SUM_W-1:0]  err_wide;
    logic [CNT_W-1:0]  err_sat, word_inc, sl_inc;

    lib_popcount #(.NBITS(NBITS)) u_popcount (
        .BITS  (ERR_IN),
        .COUNT (pc_comb)
    );

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        wcnt_d  = wcnt_q;
        wsum_d  = wsum_q;
        cnt_en  = 1'b0;
        loss    = 1'b0;
        wsum_nx = wsum_q + WSUM_W'(pc_q);
        case (state_q)
            ST_SEARCH: begin
                if (v1_q) begin
                    if (pc_q != '0) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_WORDS - 1)) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                        wcnt_d  = '0;
                        wsum_d  = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (v1_q) begin
                    cnt_en = 1'b1;
                    // Loss is checked first so it wins over a coincident window end.
                    if (wsum_nx >= WSUM_W'(LOSS_ERRS)) begin
                        loss    = 1'b1;
                        state_d = ST_SEARCH;
                        run_d   = '0;
                        wcnt_d  = '0;
                        wsum_d  = '0;
                    end else if (wcnt_q == WCNT_W'(WIN_WORDS - 1)) begin
                        wcnt_d = '0;
                        wsum_d = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        wsum_d = wsum_nx;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        err_wide = SUM_W'(ERR_CNT) + SUM_W'(pc_q);
        err_sat  = (err_wide > SUM_W'(CNT_MAX)) ? CNT_MAX : err_wide[CNT_W-1:0];
        word_inc = (WORD_CNT == CNT_MAX) ? CNT_MAX : WORD_CNT + 1'b1;
        sl_inc   = (SYNC_LOSS_CNT == CNT_MAX) ? CNT_MAX : SYNC_LOSS_CNT + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q          <= 1'b0;
            pc_q          <= '0;
            state_q       <= ST_SEARCH;
            run_q         <= '0;
            wcnt_q        <= '0;
            wsum_q        <= '0;
            ERR_PULSE     <= 1'b0;
            ERR_CNT       <= '0;
            WORD_CNT      <= '0;
            SYNC_LOSS_CNT <= '0;
        end else begin
            v1_q      <= ERR_VALID;
            pc_q      <= ERR_VALID ? pc_comb : '0;
            state_q   <= state_d;
            run_q     <= run_d;
            wcnt_q    <= wcnt_d;
            wsum_q    <= wsum_d;
            ERR_PULSE <= v1_q && (pc_q != '0);
            if (CLR_CNT) begin
                ERR_CNT       <= '0;
                WORD_CNT      <= '0;
                SYNC_LOSS_CNT <= '0;
            end else begin
                if (cnt_en) begin
                    ERR_CNT  <= err_sat;
                    WORD_CNT <= word_inc;
                end
                if (loss) SYNC_LOSS_CNT <= sl_inc;
            end
        end
    end

    assign LOCKED = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Directed bench: a per-edge reference model pushes expected outputs, popped after each edge.
module tb_prbs_err_monitor;

    localparam int LOCK = 4;
    localparam int WIN  = 8;
    localparam int LOSS = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] ERR_IN = 8'h00;
    logic       ERR_VALID = 1'b0;
    logic       CLR_CNT = 1'b0;

    logic       locked_a, pulse_a, locked_b, pulse_b;
    logic [7:0] err_a, word_a, sl_a, err_b, word_b, sl_b;

    prbs_err_monitor #(.NBITS(8), .CNT_W(8), .LOCK_WORDS(LOCK), .WIN_WORDS(WIN),
                       .LOSS_ERRS(LOSS)) dut_a (
        .CLK(CLK), .RST(RST), .ERR_IN(ERR_IN), .ERR_VALID(ERR_VALID), .CLR_CNT(CLR_CNT),
        .LOCKED(locked_a), .ERR_PULSE(pulse_a), .ERR_CNT(err_a), .WORD_CNT(word_a),
        .SYNC_LOSS_CNT(sl_a)
    );

    prbs_err_monitor #(.NBITS(8), .CNT_W(8), .LOCK_WORDS(LOCK), .WIN_WORDS(WIN),
                       .LOSS_ERRS(255)) dut_b (
        .CLK(CLK), .RST(RST), .ERR_IN(ERR_IN), .ERR_VALID(ERR_VALID), .CLR_CNT(CLR_CNT),
        .LOCKED(locked_b), .ERR_PULSE(pulse_b), .ERR_CNT(err_b), .WORD_CNT(word_b),
        .SYNC_LOSS_CNT(sl_b)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       locked;
        logic       pulse;
        logic [7:0] err;
        logic [7:0] word;
        logic [7:0] sl;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    // Reference model state for dut_a
    int m_locked, m_pulse, m_err, m_word, m_sl;
    int m_clean, m_wcnt, m_wsum, m_v1, m_pc1;

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [7:0] e, input logic v, input logic c, input logic r);
        exp_t x;
        int pc2;
        if (r) begin
            m_locked = 0; m_pulse = 0; m_err = 0; m_word = 0; m_sl = 0;
            m_clean = 0; m_wcnt = 0; m_wsum = 0; m_v1 = 0; m_pc1 = 0;
        end else begin
            pc2 = m_pc1;
            m_pulse = (m_v1 != 0 && pc2 > 0) ? 1 : 0;
            if (m_v1 != 0) begin
                if (m_locked == 0) begin
                    if (pc2 == 0) begin
                        m_clean++;
                        if (m_clean == LOCK) begin
                            m_locked = 1; m_clean = 0; m_wcnt = 0; m_wsum = 0;
                        end
                    end else begin
                        m_clean = 0;
                    end
                end else begin
                    m_word = sat8(m_word + 1);
                    m_err  = sat8(m_err + pc2);
                    m_wsum += pc2;
                    m_wcnt++;
                    if (m_wsum >= LOSS) begin
                        m_locked = 0; m_sl = sat8(m_sl + 1);
                        m_clean = 0; m_wcnt = 0; m_wsum = 0;
                    end else if (m_wcnt == WIN) begin
                        m_wcnt = 0; m_wsum = 0;
                    end
                end
            end
            if (c) begin
                m_err = 0; m_word = 0; m_sl = 0;
            end
            m_v1  = v ? 1 : 0;
            m_pc1 = v ? $countones(e) : 0;
        end
        x.locked = m_locked[0];
        x.pulse  = m_pulse[0];
        x.err    = m_err[7:0];
        x.word   = m_word[7:0];
        x.sl     = m_sl[7:0];
        sb.push_back(x);
    endtask

    task automatic step(input logic [7:0] e, input logic v, input logic c, input logic r);
        exp_t x;
        ERR_IN = e; ERR_VALID = v; CLR_CNT = c; RST = r;
        model_edge(e, v, c, r);
        @(posedge CLK);
        #1;
        x = sb.pop_front();
        chk("sb_locked", 32'(locked_a), 32'(x.locked));
        chk("sb_pulse",  32'(pulse_a),  32'(x.pulse));
        chk("sb_err",    32'(err_a),    32'(x.err));
        chk("sb_word",   32'(word_a),   32'(x.word));
        chk("sb_sync",   32'(sl_a),     32'(x.sl));
        if (pulse_a === 1'b1) n_pulse++;
    endtask

    initial begin
        // Reset
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_err",    32'(err_a),    32'd0);
        chk("rst_pulse",  32'(pulse_a),  32'd0);

        // Lock acquisition: 3 clean, one error, 4 clean
        RST = 1'b0;
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
        chk("lock_early", 32'(locked_a), 32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("lock_at_t2", 32'(locked_a), 32'd1);
        chk("lock_err",   32'(err_a),    32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // Error counting to loss of sync
        n_pulse = 0;
        step(8'h03, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h80, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("loss_err",    32'(err_a),    32'd3);
        chk("loss_sync",   32'(sl_a),     32'd1);
        chk("loss_locked", 32'(locked_a), 32'd0);
        chk("loss_word",   32'(word_a),   32'd3);
        chk("loss_pulses", 32'(n_pulse),  32'd2);

        // Window reset: relock with a counter clear, then two windows of 2 errors each
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step((i == 0 || i == 4) ? 8'h01 : 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step((i < 2) ? 8'h01 : 8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("win_locked", 32'(locked_a), 32'd1);
        chk("win_err",    32'(err_a),    32'd4);
        chk("win_word",   32'(word_a),   32'd16);

        // CLR_CNT collides with a stage-2 word carrying two errors
        step(8'h03, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_err",    32'(err_a),    32'd0);
        chk("clr_word",   32'(word_a),   32'd0);
        chk("clr_locked", 32'(locked_a), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // Reset while locked with a word sitting in stage 1
        step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_word", 32'(word_a), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_locked", 32'(locked_a), 32'd0);
        chk("mid_rst_word",   32'(word_a),   32'd0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_drop_pulse", 32'(pulse_a), 32'd0);
        chk("mid_rst_drop_err",   32'(err_a),   32'd0);

        // Saturation on the high-threshold instance
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) step(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("sat_ramp", 32'(err_b), 32'd240);
        for (int i = 0; i < 10; i++) step(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("sat_max", 32'(err_b), 32'hFF);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("sat_hold",   32'(err_b),    32'hFF);
        chk("sat_locked", 32'(locked_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
